wb_commit_stage: RTL and testbench

- Writeback-end consumer of the MEM/WB pipeline register: takes the registered writeback bundle and commits it.
- Selects the writeback data (ALU result or load data) and writes the 32-entry integer register file, which it owns.
- Resolves the branch carried in the bundle and emits a registered one-cycle redirect to the fetch stage.
- Serves two read ports to decode, with same-cycle write bypass.

---
 rtl/wb_commit_stage_pkg.sv | 29 ++
 rtl/wb_regfile.sv | 53 +++++
 rtl/wb_commit_stage.sv | 95 +++++++++
 tb/tb_wb_commit_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_stage_pkg.sv
// Shared types for the writeback commit stage: datapath widths, branch control codes,
// register index width and the branch-resolution helper.
package wb_commit_stage_pkg;

    localparam int DATA_W       = 32;
    localparam int INSTR_ADDR_W = 32;
    localparam int NREGS_DEF    = 32;
    localparam int REG_IDX_W    = 5;
    localparam int CTR_BRANCH_W = 2;

    localparam logic [CTR_BRANCH_W-1:0] BR_NONE = 2'b00;
    localparam logic [CTR_BRANCH_W-1:0] BR_EQ   = 2'b01;
    localparam logic [CTR_BRANCH_W-1:0] BR_NE   = 2'b10;
    localparam logic [CTR_BRANCH_W-1:0] BR_JMP  = 2'b11;

    function automatic logic branch_taken(input logic [CTR_BRANCH_W-1:0] ctr,
                                          input logic                    zero);
        logic taken;
        taken = 1'b0;
        case (ctr)
            BR_EQ:   taken = zero;
            BR_NE:   taken = ~zero;
            BR_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/wb_regfile.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero,
// and a write-before-read bypass so decode sees the value being committed this cycle.
module wb_regfile
    import wb_commit_stage_pkg::*;
#(
    parameter int XLEN  = DATA_W,
    parameter int NREGS = NREGS_DEF,
    parameter int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [IDX_W-1:0] i_raddr1,
    input  logic [IDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]  o_rdata1,
    output logic [XLEN-1:0]  o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_valid;

    assign w_wr_valid = i_we && (i_waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Index 0 wins over the bypass so a write aimed at x0 is never visible.
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        if (i_raddr1 == '0)
            o_rdata1 = '0;
        else if (i_we && i_waddr == i_raddr1)
            o_rdata1 = i_wdata;
    end

    always_comb begin
        o_rdata2 = r_regs[i_raddr2];
        if (i_raddr2 == '0)
            o_rdata2 = '0;
        else if (i_we && i_waddr == i_raddr2)
            o_rdata2 = i_wdata;
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback commit: selects write data, updates the register file and issues a registered
// one-cycle fetch redirect for taken branches. Define WB_RETIRE_COUNTER_EN to add retire counters.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter int XLEN  = DATA_W,
    parameter int NREGS = NREGS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [XLEN-1:0]           pc_wb_i,
    input  logic                      registerWriteEnable_i,
    input  logic                      regSelect_i,
    input  logic [$clog2(NREGS)-1:0]  rd_i,
    input  logic [CTR_BRANCH_W-1:0]   branchCtr_i,
    input  logic [XLEN-1:0]           aluSrc_i,
    input  logic [XLEN-1:0]           rdData_i,
    input  logic [XLEN-1:0]           offset_i,
    input  logic                      zero_i,
    input  logic [$clog2(NREGS)-1:0]  rs1_i,
    input  logic [$clog2(NREGS)-1:0]  rs2_i,
    output logic [XLEN-1:0]           rs1Data_o,
    output logic [XLEN-1:0]           rs2Data_o,
    output logic                      redirect_o,
    output logic [XLEN-1:0]           redirectPc_o
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]               retireCount_o,
    output logic [31:0]               takenCount_o
`endif
);

    logic [XLEN-1:0] w_wdata;
    logic            w_taken;
    logic            r_redirect;
    logic [XLEN-1:0] r_redirect_pc;

    assign w_wdata = regSelect_i ? rdData_i : aluSrc_i;
    assign w_taken = branch_taken(branchCtr_i, zero_i);

    wb_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst),
        .i_we     (registerWriteEnable_i),
        .i_waddr  (rd_i),
        .i_wdata  (w_wdata),
        .i_raddr1 (rs1_i),
        .i_raddr2 (rs2_i),
        .o_rdata1 (rs1Data_o),
        .o_rdata2 (rs2Data_o)
    );

    // The target only moves on a taken bundle, so it holds while the pulse is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_redirect <= w_taken;
            if (w_taken)
                r_redirect_pc <= pc_wb_i + offset_i;
        end
    end

    assign redirect_o   = r_redirect;
    assign redirectPc_o = r_redirect_pc;

`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0] r_retire_cnt;
    logic [31:0] r_taken_cnt;
    logic        w_retire;

    // Writes to x0 still retire an instruction, so rd is not consulted here.
    assign w_retire = registerWriteEnable_i || (branchCtr_i != BR_NONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + 64'd1;
            if (w_taken)
                r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign retireCount_o = r_retire_cnt;
    assign takenCount_o  = r_taken_cnt;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: reset, write select, x0/bypass, branch decode,
// wrap/back-to-back redirects and, with WB_RETIRE_COUNTER_EN, the retire counters.
module tb_wb_commit_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc_wb_i;
    logic            registerWriteEnable_i;
    logic            regSelect_i;
    logic [4:0]      rd_i;
    logic [1:0]      branchCtr_i;
    logic [XLEN-1:0] aluSrc_i;
    logic [XLEN-1:0] rdData_i;
    logic [XLEN-1:0] offset_i;
    logic            zero_i;
    logic [4:0]      rs1_i;
    logic [4:0]      rs2_i;
    logic [XLEN-1:0] rs1Data_o;
    logic [XLEN-1:0] rs2Data_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirectPc_o;
`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0]     retireCount_o;
    logic [31:0]     takenCount_o;
`endif

    int n_cmp;
    int n_fail;

    wb_commit_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_wb_i               (pc_wb_i),
        .registerWriteEnable_i (registerWriteEnable_i),
        .regSelect_i           (regSelect_i),
        .rd_i                  (rd_i),
        .branchCtr_i           (branchCtr_i),
        .aluSrc_i              (aluSrc_i),
        .rdData_i              (rdData_i),
        .offset_i              (offset_i),
        .zero_i                (zero_i),
        .rs1_i                 (rs1_i),
        .rs2_i                 (rs2_i),
        .rs1Data_o             (rs1Data_o),
        .rs2Data_o             (rs2Data_o),
        .redirect_o            (redirect_o),
        .redirectPc_o          (redirectPc_o)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .retireCount_o         (retireCount_o),
        .takenCount_o          (takenCount_o)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        registerWriteEnable_i = 1'b0;
        regSelect_i           = 1'b0;
        rd_i                  = 5'd0;
        branchCtr_i           = 2'b00;
        aluSrc_i              = '0;
        rdData_i              = '0;
        pc_wb_i               = '0;
        offset_i              = '0;
        zero_i                = 1'b0;
    endtask

    task automatic drive_write(input logic sel, input logic [4:0] rd,
                               input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld);
        registerWriteEnable_i = 1'b1;
        regSelect_i           = sel;
        rd_i                  = rd;
        aluSrc_i              = alu;
        rdData_i              = ld;
    endtask

    task automatic drive_branch(input logic [1:0] ctr, input logic z,
                                input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off);
        branchCtr_i = ctr;
        zero_i      = z;
        pc_wb_i     = pc;
        offset_i    = off;
    endtask

    task automatic check32(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        rs1_i = 5'd1;
        rs2_i = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        check1 ("reset_redirect", redirect_o, 1'b0);
        check32("reset_redirect_pc", redirectPc_o, 32'h0);
        check32("reset_x1", rs1Data_o, 32'h0);
        check32("reset_x31", rs2Data_o, 32'h0);
        rst = 1'b1;
        // write x5 and issue a jump so both state kinds are live when reset hits
        drive_write(1'b0, 5'd5, 32'h0000_1234, 32'h0);
        drive_branch(2'b11, 1'b0, 32'h40, 32'h4);
        tick();
        drive_idle();
        rs1_i = 5'd5;
        #1;
        check32("pre_reset_x5", rs1Data_o, 32'h0000_1234);
        check1 ("pre_reset_redirect", redirect_o, 1'b1);
        check32("pre_reset_redirect_pc", redirectPc_o, 32'h44);
        #2 rst = 1'b0;
        #1;
        check32("async_reset_x5", rs1Data_o, 32'h0);
        check1 ("async_reset_redirect", redirect_o, 1'b0);
        check32("async_reset_redirect_pc", redirectPc_o, 32'h0);
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_select();
        drive_write(1'b0, 5'd3, 32'hA5A5_0000, 32'h1111_1111);
        tick();
        drive_write(1'b1, 5'd4, 32'h2222_2222, 32'hDEAD_BEEF);
        tick();
        drive_idle();
        rs1_i = 5'd3;
        rs2_i = 5'd4;
        #1;
        check32("wsel_alu_x3", rs1Data_o, 32'hA5A5_0000);
        check32("wsel_load_x4", rs2Data_o, 32'hDEAD_BEEF);
    endtask

    task automatic test_x0_bypass();
        drive_write(1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0);
        rs1_i = 5'd0;
        rs2_i = 5'd0;
        #1;
        check32("x0_no_bypass", rs1Data_o, 32'h0);
        tick();
        drive_idle();
        #1;
        check32("x0_after_write", rs2Data_o, 32'h0);
        rs2_i = 5'd7;
        #1;
        check32("x7_before_write", rs2Data_o, 32'h0);
        drive_write(1'b0, 5'd7, 32'h0000_0055, 32'h0);
        #1;
        check32("x7_bypass_same_cycle", rs2Data_o, 32'h0000_0055);
        tick();
        drive_idle();
        #1;
        check32("x7_committed", rs2Data_o, 32'h0000_0055);
    endtask

    task automatic test_branch();
        logic [1:0]      ctr_t [6];
        logic            z_t   [6];
        logic [XLEN-1:0] pc_t  [6];
        logic            tk_t  [6];
        logic [XLEN-1:0] exp_pc;
        ctr_t = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
        z_t   = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1 };
        pc_t  = '{32'h100, 32'h200, 32'h100, 32'h100, 32'h300, 32'h400};
        tk_t  = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0 };
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            drive_branch(ctr_t[i], z_t[i], pc_t[i], 32'h20);
            tick();
            drive_idle();
            if (tk_t[i])
                exp_pc = pc_t[i] + 32'h20;
            check1 ($sformatf("br%0d_pulse", i), redirect_o, tk_t[i]);
            check32($sformatf("br%0d_target", i), redirectPc_o, exp_pc);
            tick();
            check1 ($sformatf("br%0d_pulse_drop", i), redirect_o, 1'b0);
            check32($sformatf("br%0d_target_hold", i), redirectPc_o, exp_pc);
        end
    endtask

    task automatic test_back_to_back();
        // first bundle also commits a write to show both commit on one edge
        drive_branch(2'b11, 1'b0, 32'hFFFF_FFFC, 32'h8);
        drive_write(1'b1, 5'd9, 32'h0, 32'h0000_0099);
        tick();
        registerWriteEnable_i = 1'b0;
        drive_branch(2'b11, 1'b0, 32'hFFFF_FFF0, 32'h8);
        check1 ("b2b_first_pulse", redirect_o, 1'b1);
        check32("b2b_first_wrap_target", redirectPc_o, 32'h0000_0004);
        tick();
        drive_idle();
        rs1_i = 5'd9;
        #1;
        check1 ("b2b_second_pulse", redirect_o, 1'b1);
        check32("b2b_second_target", redirectPc_o, 32'hFFFF_FFF8);
        check32("b2b_write_x9", rs1Data_o, 32'h0000_0099);
        tick();
        check1 ("b2b_third_drop", redirect_o, 1'b0);
        check32("b2b_third_hold", redirectPc_o, 32'hFFFF_FFF8);
    endtask

`ifdef WB_RETIRE_COUNTER_EN
    task automatic test_counters();
        rst = 1'b0;
        drive_idle();
        #3;
        n_cmp++;
        if (retireCount_o !== 64'd0) begin
            n_fail++;
            $display("FAIL cnt_reset_retire: got %0d expected 0", retireCount_o);
        end
        check32("cnt_reset_taken", takenCount_o, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_write(1'b0, 5'(i), 32'(i + 1), 32'h0);
            tick();
        end
        drive_idle();
        drive_branch(2'b01, 1'b1, 32'h10, 32'h4);
        tick();
        drive_branch(2'b10, 1'b1, 32'h10, 32'h4);
        tick();
        drive_branch(2'b11, 1'b0, 32'h10, 32'h4);
        tick();
        drive_idle();
        tick();
        tick();
        n_cmp++;
        if (retireCount_o !== 64'd8) begin
            n_fail++;
            $display("FAIL cnt_retire: got %0d expected 8", retireCount_o);
        end
        check32("cnt_taken", takenCount_o, 32'd2);
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rs1_i  = 5'd0;
        rs2_i  = 5'd0;
        drive_idle();
        test_reset();
        test_write_select();
        test_x0_bypass();
        test_branch();
        test_back_to_back();
`ifdef WB_RETIRE_COUNTER_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
